rr_arbiter_4: RTL and testbench
===============================

# rr_arbiter_4

Four-requester round-robin arbiter that owns the select and enable inputs of the 2-to-4 decoder datapath. It grants the shared resource to one requester at a time. The owner keeps the grant until it releases, drops its request, or hits a hold-time limit. The decoder is driven with the owner index and an enable, and a one-cycle dead gap separates consecutive grants.

## Interface
- MAX_HOLD, default 8: maximum consecutive GRANT cycles per grant. Legal range is 1..2^CNT_W.
- CNT_W, default 4: width of the hold counter.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  4  request vector; bit i is requester i.
- release  in  1  current owner finished; sampled only in GRANT.
- grant  out  4  one-hot grant, or all-zero when no owner.
- sel  out  2  owner index to the decoder; A = sel[1], B = sel[0].
- dec_en  out  1  decoder enable; high only in GRANT.
- busy  out  1  high while in GRANT.
- timeout  out  1  one-cycle pulse marking a forced release.

## Operation
- States are IDLE, GRANT and GAP. All outputs are registered.
- Round-robin pointer `last` (2 bits) holds the index of the most recent owner. The search order is last+1, last+2, last+3, last, modulo 4. The winner is the first set bit of req in that order.
- **IDLE:**
  - If req is nonzero, go to GRANT with owner = winner, grant = one-hot(winner), sel = winner, dec_en = 1 and hold_cnt = 0.
  - Otherwise stay in IDLE.
- **GRANT:** hold_cnt increments each cycle. Exit conditions are evaluated in this priority order:
  - release = 1 → GAP.
  - req[owner] = 0 → GAP.
  - hold_cnt = MAX_HOLD-1 → GAP, with timeout = 1 during the GAP cycle.
  - Otherwise stay in GRANT.
  - On every exit, last is set to owner.
- **GAP:** exactly one cycle, with grant = 0, dec_en = 0 and sel held.
  - Arbitration runs in this cycle using the updated pointer.
  - If req is nonzero, go to GRANT; otherwise go to IDLE.
- An exit caused by release or by a request drop in the same cycle as hold_cnt = MAX_HOLD-1 is not a timeout; timeout stays 0.
- release outside GRANT is ignored. Requests from non-owners never preempt the owner.
- Output invariants:
  - grant is zero or one-hot.
  - dec_en = busy = (grant != 0).
  - sel equals the owner index whenever dec_en = 1.
- hold_cnt arithmetic is unsigned CNT_W bits and never wraps, because the exit triggers at MAX_HOLD-1.

## Timing
- Reset values: state IDLE, grant 0000, sel 00, dec_en 0, busy 0, timeout 0, last 11 (so the first search starts at requester 0), hold_cnt 0.
- Reset asserted in any state returns all outputs to reset values on the next edge. It has priority over every transition.
- Request latency:
  - A req sampled in IDLE at edge N produces grant at edge N+1.
  - A req sampled in GAP produces grant on the following edge.
- Grant duration:
  - An owner holding req without release sees exactly MAX_HOLD cycles of grant, then one GAP cycle.
  - MAX_HOLD = 1 gives single-cycle grants.
- Back-to-back grants are always separated by exactly one cycle with dec_en = 0.
- timeout is high only in the GAP cycle that follows a forced exit.

## Structure
- Shared package `arb_pkg`:
  - state enum (IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2);
  - requester count constant NREQ = 4 and its index width;
  - default MAX_HOLD value.
- One sub-module, `rr_pick_4`: combinational rotating-priority picker.
  - Inputs: req[3:0] and last[1:0].
  - Outputs: valid and idx[1:0].
- The FSM, hold counter and output registers live in the top module.

## Test plan
- Reset, then req = 0001 → next cycle grant = 0001, sel = 00, dec_en = 1, busy = 1.
- req = 1111 held, with release pulsed on the 2nd GRANT cycle of each grant:
  - grant sequence is 0001, 0010, 0100, 1000, 0001;
  - each grant is separated by one cycle of grant = 0000 and dec_en = 0.
- MAX_HOLD = 8, req = 0100 held with no release → grant = 0100 for 8 cycles, then GAP with timeout = 1, then grant = 0100 again.
- Owner drop: req = 0010 granted, then req goes to 0000 → next cycle GAP with timeout = 0, then IDLE with all outputs 0.
- Mid-grant reset: reset during grant = 1000 → next cycle all outputs are at reset values. Then req = 1001 → grant = 0001, which confirms the pointer reset.
- Simultaneous events with MAX_HOLD = 4: release on the 4th GRANT cycle → GAP with timeout = 0.
- Release while IDLE → no state change.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ==== arb_pkg : state encoding and constants shared by the arbiter files | rev 1.0 ====
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int NREQ             = 4;
  localparam int IDX_W            = $clog2(NREQ);
  localparam int MAX_HOLD_DEFAULT = 8;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick_4.sv
`default_nettype none
// ==== rr_pick_4 : combinational rotating-priority picker, search starts after last | rev 1.0 ====
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Walk from lowest to highest priority so the last hit (last+1) wins.
    for (int k = NREQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ==== rr_arbiter_4 : round-robin arbiter owning the 2-to-4 decoder select/enable | rev 1.0 ====
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             release_req,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] sel,
  output logic             dec_en,
  output logic             busy,
  output logic             timeout
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] last, last_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [NREQ-1:0]  grant_nxt;
  logic [IDX_W-1:0] sel_nxt;
  logic             en_nxt;
  logic             timeout_nxt;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             at_limit;

  rr_pick_4 u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign at_limit = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // sel doubles as the owner index: it is only ever loaded with the winner.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    cnt_nxt     = hold_cnt;
    grant_nxt   = '0;
    sel_nxt     = sel;
    en_nxt      = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_nxt = GRANT;
          grant_nxt = onehot(pick_idx);
          sel_nxt   = pick_idx;
          en_nxt    = 1'b1;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
          sel_nxt   = '0;
        end
      end
      GRANT: begin
        if (release_req || !req[sel] || at_limit) begin
          state_nxt   = GAP;
          last_nxt    = sel;
          timeout_nxt = !release_req && req[sel];
        end else begin
          grant_nxt = grant;
          en_nxt    = 1'b1;
          cnt_nxt   = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= '1;
      hold_cnt <= '0;
      grant    <= '0;
      sel      <= '0;
      dec_en   <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= cnt_nxt;
      grant    <= grant_nxt;
      sel      <= sel_nxt;
      dec_en   <= en_nxt;
      busy     <= en_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ==== tb_rr_arbiter_4 : scoreboard bench for rr_arbiter_4 against a cycle-level reference | rev 1.0 ====
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic       clk         = 1'b0;
  logic       reset       = 1'b1;
  logic       release_req = 1'b0;
  logic [3:0] req         = 4'b0000;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       dec_en;
  logic       busy;
  logic       timeout;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .release_req (release_req),
    .grant       (grant),
    .sel         (sel),
    .dec_en      (dec_en),
    .busy        (busy),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       dec_en;
    logic       busy;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference: who owns the resource, how many grant cycles it has had, and the pointer.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 3;
  int m_sel   = 0;
  bit m_to    = 1'b0;

  function automatic int rr_winner(input logic [3:0] r, input int last);
    for (int d = 1; d <= 4; d++)
      if (r[(last + d) % 4]) return (last + d) % 4;
    return -1;
  endfunction

  task automatic model_step(input bit rs, input logic [3:0] r, input bit rl);
    exp_t e;
    int   w;
    if (rs) begin
      m_owner = -1; m_held = 0; m_last = 3; m_sel = 0; m_to = 1'b0;
    end else if (m_owner >= 0) begin
      if (rl || !r[m_owner] || m_held == MAX_HOLD) begin
        m_to    = !rl && r[m_owner];
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else begin
      m_to = 1'b0;
      w    = rr_winner(r, m_last);
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_sel = w;
      end else begin
        m_sel = 0;
      end
    end
    e.grant   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.sel     = 2'(m_sel);
    e.dec_en  = (m_owner >= 0);
    e.busy    = (m_owner >= 0);
    e.timeout = m_to;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rs, input logic [3:0] r, input bit rl);
    @(negedge clk);
    reset       = rs;
    req         = r;
    release_req = rl;
    model_step(rs, r, rl);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({grant, sel, dec_en, busy, timeout} !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got grant=%b sel=%0d en=%b busy=%b to=%b want grant=%b sel=%0d en=%b busy=%b to=%b",
                   $time, grant, sel, dec_en, busy, timeout,
                   e.grant, e.sel, e.dec_en, e.busy, e.timeout);
        end
      end
    end
  end

  initial begin : stim
    logic [3:0] cur_req;
    bit         rs;
    bit         rl;
    drive(1, 4'b0000, 0);
    drive(1, 4'b0000, 0);
    // first request after reset, then drop to idle
    repeat (4) drive(0, 4'b0001, 0);
    repeat (3) drive(0, 4'b0000, 0);
    // full rotation from a fresh pointer, release on the 2nd grant cycle
    drive(1, 4'b0000, 0);
    repeat (16) drive(0, 4'b1111, (m_owner >= 0) && (m_held == 2));
    drive(0, 4'b0000, 1);
    repeat (2) drive(0, 4'b0000, 0);
    // continuous single request hits the hold limit
    repeat (22) drive(0, 4'b0100, 0);
    // owner drops its request
    repeat (2) drive(0, 4'b0010, 0);
    repeat (3) drive(0, 4'b0000, 0);
    // reset in the middle of a grant, pointer must restart at requester 0
    repeat (3) drive(0, 4'b1000, 0);
    drive(1, 4'b1000, 0);
    repeat (3) drive(0, 4'b1001, 0);
    drive(0, 4'b1001, 1);
    repeat (2) drive(0, 4'b0000, 0);
    // release coinciding with the final hold cycle
    repeat (12) drive(0, 4'b0001, (m_owner >= 0) && (m_held == MAX_HOLD));
    // request drop coinciding with the final hold cycle
    repeat (12) drive(0, ((m_owner >= 0) && (m_held == MAX_HOLD)) ? 4'b0000 : 4'b0010, 0);
    // release while idle is ignored
    drive(0, 4'b0000, 0);
    repeat (3) drive(0, 4'b0000, 1);
    // randomized traffic
    cur_req = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom_range(0, 15));
      rl = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 99) == 0);
      drive(rs, cur_req, rl);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got no end of stimulus by %0t want finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
